// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the instruction-fetch port (read-only)
// and the load/store port. Each access holds the strobe for MEM_LATENCY cycles, then acks for one cycle.
module mem_port_arbiter #(
   parameter int WORD_SIZE   = 16,
   parameter int MEM_LATENCY = 3
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_req,
   input  logic [WORD_SIZE-1:0] i_addr,
   output logic                 i_ack,
   output logic [WORD_SIZE-1:0] i_rdata,
   input  logic                 d_req,
   input  logic                 d_we,
   input  logic [WORD_SIZE-1:0] d_addr,
   input  logic [WORD_SIZE-1:0] d_wdata,
   output logic                 d_ack,
   output logic [WORD_SIZE-1:0] d_rdata,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic [WORD_SIZE-1:0] mem_addr,
   output logic [WORD_SIZE-1:0] mem_wdata,
   input  logic [WORD_SIZE-1:0] mem_rdata,
   output logic                 busy,
   output logic                 owner_d
);

   typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

   state_t     state, state_nxt;
   logic [3:0] cnt;
   logic       last_d;
   logic       we_q;
   logic       any_req;
   logic       grant_d;

   // On a tie, D wins only if I was granted last.
   assign any_req = i_req | d_req;
   assign grant_d = d_req & (~i_req | ~last_d);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      i_ack     = 1'b0;
      d_ack     = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) state_nxt = BUSY;
         end
         BUSY: begin
            busy      = 1'b1;
            mem_read  = ~we_q;
            mem_write = we_q;
            if (cnt == 4'd0) state_nxt = ACK;
         end
         ACK: begin
            busy      = 1'b1;
            i_ack     = ~owner_d;
            d_ack     = owner_d;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt       <= 4'd0;
         last_d    <= 1'b1;
         owner_d   <= 1'b0;
         we_q      <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_rdata   <= '0;
         d_rdata   <= '0;
      end else if (state == IDLE) begin
         if (any_req) begin
            owner_d   <= grant_d;
            we_q      <= grant_d & d_we;
            mem_addr  <= grant_d ? d_addr : i_addr;
            mem_wdata <= d_wdata;
            cnt       <= CNT_LOAD;
         end
      end else if (state == BUSY) begin
         if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end else begin
            last_d <= owner_d;
            if (!we_q) begin
               if (owner_d) d_rdata <= mem_rdata;
               else         i_rdata <= mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random two-requester traffic against a transaction-level model of the arbiter:
// grant edges, strobe/ack windows and returned data are predicted arithmetically.
module tb_mem_port_arbiter;

   localparam int W     = 16;
   localparam int LAT   = 3;
   localparam int AW    = 5;
   localparam int N_CYC = 3000;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [W-1:0] i_addr = '0, d_addr = '0, d_wdata = '0;
   logic         i_ack, d_ack, mem_read, mem_write, busy, owner_d;
   logic [W-1:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(LAT)) dut (
      .clk(clk), .reset_n(reset_n),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .owner_d(owner_d)
   );

   function automatic logic [W-1:0] seed_word(input int a);
      return W'(a * 40503 + 7467);
   endfunction

   // Memory environment: unwritten words read back their seed value.
   logic [W-1:0] env_mem [0:(1<<AW)-1];
   bit           env_wr  [0:(1<<AW)-1];
   assign mem_rdata = env_wr[mem_addr[AW-1:0]] ? env_mem[mem_addr[AW-1:0]]
                                               : seed_word(int'(mem_addr[AW-1:0]));
   always @(posedge clk) begin
      if (mem_write) begin
         env_mem[mem_addr[AW-1:0]] <= mem_wdata;
         env_wr[mem_addr[AW-1:0]]  <= 1'b1;
      end
   end

   // Reference model state
   logic [W-1:0] ref_mem [0:(1<<AW)-1];
   int           cyc, g_edge, next_sample;
   bit           g_d, g_we, last_d, exp_owner, rand_on;
   logic [W-1:0] g_addr, g_wdata, g_rd, exp_i_rd, exp_d_rd;
   int           n_checks = 0, n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [W-1:0] rand_addr();
      return W'($urandom_range((1 << AW) - 1));
   endfunction

   task automatic new_d();
      d_we    = 1'($urandom_range(1));
      d_addr  = rand_addr();
      d_wdata = W'($urandom);
   endtask

   task automatic model_reset();
      g_edge = -100; g_d = 1'b0; g_we = 1'b0;
      last_d = 1'b1; exp_owner = 1'b0;
      exp_i_rd = '0; exp_d_rd = '0;
      next_sample = -1;
   endtask

   // Decide what the upcoming clock edge does, from the inputs now being driven.
   task automatic predict();
      int e;
      e = cyc + 1;
      if (e != next_sample) return;
      if (i_req || d_req) begin
         g_d     = d_req && (!i_req || !last_d);
         last_d  = g_d;
         g_edge  = e;
         g_we    = g_d && d_we;
         g_addr  = g_d ? d_addr : i_addr;
         g_wdata = d_wdata;
         if (g_we) ref_mem[g_addr[AW-1:0]] = g_wdata;
         else      g_rd = ref_mem[g_addr[AW-1:0]];
         next_sample = e + LAT + 2;
      end else begin
         next_sample = e + 1;
      end
   endtask

   task automatic check_cycle();
      bit strobe, ack_c;
      strobe = (cyc >= g_edge) && (cyc < g_edge + LAT);
      ack_c  = (cyc == g_edge + LAT);
      if (cyc == g_edge) exp_owner = g_d;
      if (ack_c && !g_we) begin
         if (g_d) exp_d_rd = g_rd;
         else     exp_i_rd = g_rd;
      end
      check("i_ack",     32'(i_ack),     32'(ack_c && !g_d));
      check("d_ack",     32'(d_ack),     32'(ack_c && g_d));
      check("mem_read",  32'(mem_read),  32'(strobe && !g_we));
      check("mem_write", 32'(mem_write), 32'(strobe && g_we));
      check("busy",      32'(busy),      32'(strobe || ack_c));
      check("owner_d",   32'(owner_d),   32'(exp_owner));
      if (strobe) begin
         check("mem_addr", 32'(mem_addr), 32'(g_addr));
         if (g_we) check("mem_wdata", 32'(mem_wdata), 32'(g_wdata));
      end
      check("i_rdata", 32'(i_rdata), 32'(exp_i_rd));
      check("d_rdata", 32'(d_rdata), 32'(exp_d_rd));
   endtask

   // Requesters: hold until ack, then drop or chain a new access; after a
   // grant, address/data may wander to show the latched copies are used.
   task automatic drive();
      bit ack_c, granted_win;
      ack_c       = (cyc == g_edge + LAT);
      granted_win = (cyc >= g_edge) && (cyc < g_edge + LAT);
      if (i_req) begin
         if (ack_c && !g_d) begin
            if ($urandom_range(3) == 0) i_req = 1'b0;
            else                        i_addr = rand_addr();
         end else if (granted_win && !g_d && $urandom_range(3) == 0) begin
            i_addr = rand_addr();
         end
      end else if ($urandom_range(2) == 0) begin
         i_req  = 1'b1;
         i_addr = rand_addr();
      end
      if (d_req) begin
         if (ack_c && g_d) begin
            if ($urandom_range(3) == 0) d_req = 1'b0;
            else                        new_d();
         end else if (granted_win && g_d && $urandom_range(3) == 0) begin
            d_addr  = rand_addr();
            d_wdata = W'($urandom);
         end
      end else if ($urandom_range(2) == 0) begin
         d_req = 1'b1;
         new_d();
      end
   endtask

   task automatic step();
      predict();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_cycle();
      if (rand_on) drive();
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) ref_mem[i] = seed_word(i);
      cyc = 0;
      rand_on = 1'b1;
      model_reset();

      repeat (2) @(negedge clk);
      check("rst_i_ack",     32'(i_ack),     32'd0);
      check("rst_d_ack",     32'(d_ack),     32'd0);
      check("rst_mem_read",  32'(mem_read),  32'd0);
      check("rst_mem_write", 32'(mem_write), 32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_owner_d",   32'(owner_d),   32'd0);
      check("rst_mem_addr",  32'(mem_addr),  32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      check("rst_i_rdata",   32'(i_rdata),   32'd0);
      check("rst_d_rdata",   32'(d_rdata),   32'd0);

      // Both requesters rise together straight after reset: I must win.
      i_req  = 1'b1;
      i_addr = rand_addr();
      d_req  = 1'b1;
      new_d();
      reset_n     = 1'b1;
      next_sample = cyc + 1;
      repeat (N_CYC) step();

      // Drain, then abort a fetch with reset in its second strobe cycle.
      rand_on = 1'b0;
      i_req   = 1'b0;
      d_req   = 1'b0;
      repeat (LAT + 3) step();
      i_req  = 1'b1;
      i_addr = W'(5);
      for (int k = 0; k < 8 && cyc != g_edge + 1; k++) step();
      check("abort_reached", 32'(cyc == g_edge + 1), 32'd1);
      i_req   = 1'b0;
      reset_n = 1'b0;
      #1;
      check("abort_mem_read", 32'(mem_read), 32'd0);
      check("abort_busy",     32'(busy),     32'd0);
      check("abort_i_ack",    32'(i_ack),    32'd0);
      check("abort_owner_d",  32'(owner_d),  32'd0);
      check("abort_i_rdata",  32'(i_rdata),  32'd0);
      model_reset();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_cycle();
      reset_n     = 1'b1;
      next_sample = cyc + 1;
      i_req  = 1'b1;
      i_addr = W'(9);
      repeat (2 * (LAT + 2)) step();
      i_req = 1'b0;
      repeat (LAT + 3) step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported 16-bit unified memory between two requesters: the instruction-fetch side (I, read-only) and the load/store side (D, read/write).
- Sequences each access over a fixed multi-cycle memory latency and owns mem_read/mem_write/address/data-out.
- Returns read data and a one-cycle ack to the requester that was granted.
- Sits between the multicycle control/datapath and the memory model; the controller's fetch and MEM phases become request/ack handshakes on this block.

Parameters:
- WORD_SIZE, 16, width of addresses and data words.
- MEM_LATENCY, 3, cycles mem_read/mem_write are held per access; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- i_req  input  1  fetch request; held high until i_ack.
- i_addr  input  WORD_SIZE  fetch address; stable while i_req is high.
- i_ack  output  1  one-cycle pulse: fetch complete, i_rdata valid.
- i_rdata  output  WORD_SIZE  registered fetch data; holds its value until the next fetch completes.
- d_req  input  1  data request; held high until d_ack.
- d_we  input  1  1 = store, 0 = load; stable while d_req is high.
- d_addr  input  WORD_SIZE  data address.
- d_wdata  input  WORD_SIZE  store data.
- d_ack  output  1  one-cycle pulse: data access complete.
- d_rdata  output  WORD_SIZE  registered load data; unchanged by stores.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_addr  output  WORD_SIZE  memory address.
- mem_wdata  output  WORD_SIZE  memory write data.
- mem_rdata  input  WORD_SIZE  memory read data; valid in the last strobe cycle.
- busy  output  1  high in BUSY and ACK.
- owner_d  output  1  current or last grant: 1 = D, 0 = I.

Behaviour:
- Reset (asynchronous, immediate): state IDLE, counter 0, last grant = D (so I wins the first tie).
  - All outputs 0: acks, strobes, busy, owner_d, mem_addr, mem_wdata, i_rdata, d_rdata.
  - Reset during BUSY drops the strobes immediately; the aborted access gets no ack, and memory contents at that address after an aborted store are undefined.
- States: IDLE, BUSY, ACK.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request high: grant it.
  - Both high: grant the requester that was not granted last (two-way round-robin).
  - On the grant edge, latch owner, address, write data and we (forced 0 for I). Load counter with MEM_LATENCY-1 and go to BUSY.
- BUSY:
  - Strobes come from latched values only: mem_read = !we, mem_write = we.
  - mem_addr and mem_wdata are driven from the latched registers.
  - Each edge decrements the counter.
  - When counter == 0 at an edge:
    - On a load or fetch, capture mem_rdata into the owner's rdata register.
    - Update last grant, go to ACK.
  - Strobes are therefore high for exactly MEM_LATENCY cycles.
- ACK:
  - Owner's ack is high for exactly one cycle; strobes are low; return to IDLE at the next edge.
  - ACK never samples requests.
- Latency: request sampled at edge k; strobes high in cycles k+1..k+MEM_LATENCY; ack high in cycle k+MEM_LATENCY+1.
  - Back-to-back accesses are separated by one IDLE cycle; the minimum period is MEM_LATENCY+2 cycles.
- Requester rule: drop req in the cycle after ack unless another access is wanted. A req still high in IDLE is a new request.
- Request or data changes during BUSY/ACK are ignored because latched values are used.
- Both requesters held high continuously: grants strictly alternate I, D, I, D...; neither starves.
- i_ack and d_ack are never high in the same cycle.
- mem_read and mem_write are never high together.

Test Plan:
- Single fetch, MEM_LATENCY=3: i_req=1, i_addr=0x0010, memory returns 0x1234 → mem_read high exactly 3 cycles with mem_addr=0x0010; i_ack pulses 1 cycle, 4 cycles after request sampled; i_rdata=0x1234.
- Store then load: d_we=1, d_addr=0x0040, d_wdata=0xBEEF; then d_we=0, same address → mem_write for 3 cycles; d_ack; d_rdata unchanged after the store; load returns 0xBEEF.
- Simultaneous requests after reset, both held high → grant order I, D, I, D; owner_d toggles each access; no double ack; each access MEM_LATENCY+2 cycles apart.
- Request/data change mid-BUSY: d_addr 0x0040→0x0050 and d_wdata changed during BUSY → mem_addr stays 0x0040 and write data is the originally latched value.
- Reset mid-BUSY: assert reset_n=0 in the second strobe cycle → strobes, busy and acks go 0 without a clock edge; after release, state IDLE and a new i_req completes normally.
- MEM_LATENCY=1: one-cycle strobe, ack 2 cycles after request; a held req with no drop yields a new access every 3 cycles.
